// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP encoding,
// and the instruction-memory loader state encoding.
// Ports: none (package).
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } imem_ldr_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler; word_valid is combinational with the
// 4th accepted byte, and word_data then carries the complete word.
// Ports: clk/rst_n (sync active-low), clr, byte_en/byte_data in, word_valid/word_data out.
module imem_loader_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  cnt;
  logic [31:0] acc_q;

  // Merge the incoming byte into its lane so the full word is available in
  // the same cycle the last byte arrives.
  always_comb begin
    word_data = acc_q;
    word_data[8*cnt +: 8] = byte_data;
    word_valid = byte_en && (cnt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      acc_q <= 32'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else if (byte_en) begin
      acc_q <= word_data;
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory words, then pads the
// remaining memory with NOPs while holding the core.
// Ports: clk/rst_n (sync active-low), start/len request, s_valid/s_ready/s_data
// byte stream, wr_en/wr_addr/wr_data memory write, core_hold/busy/done/err status.
module imem_loader
  import riscv_pkg::*;
#(
  parameter  int XLEN        = riscv_pkg::XLEN,
  parameter  int DEPTH_WORDS = 64,
  localparam int AW          = (DEPTH_WORDS <= 1) ? 1 : $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_WORDS - 1);

  imem_ldr_state_t state, state_nxt;

  logic [AW:0]     len_q;
  logic [AW:0]     widx;      // words fully received so far
  logic            accept_start;
  logic            len_bad;
  logic            byte_acc;
  logic            word_vld;
  logic [31:0]     word_dat;
  logic            last_wr;
  logic            pad_last;
  logic [XLEN-1:0] nop_ext;

  assign nop_ext = XLEN'(INSTR_NOP);

  imem_loader_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept_start),
    .byte_en    (byte_acc),
    .byte_data  (s_data),
    .word_valid (word_vld),
    .word_data  (word_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    len_bad      = (len == '0) || (len > DEPTH_L);
    // Stop taking bytes once the last word is in, so the state can stay in
    // LOAD for the cycle that presents the final write.
    s_ready      = (state == LOAD) && (widx != len_q);
    byte_acc     = s_valid && s_ready;
    last_wr      = (state == LOAD) && wr_en && (widx == len_q);
    pad_last     = (state == PAD) && (wr_addr == LAST_ADDR);
    busy         = (state == LOAD) || (state == PAD);
    core_hold    = busy;
    done         = (state == DONE);
    err          = (state == ERR);

    case (state)
      IDLE, DONE, ERR: begin
        if (accept_start) begin
          state_nxt = len_bad ? ERR : LOAD;
        end
      end
      LOAD: begin
        if (last_wr) begin
          state_nxt = (len_q == DEPTH_L) ? DONE : PAD;
        end
      end
      PAD: begin
        if (pad_last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writes are registered: each one is scheduled on the edge before the
  // cycle it is presented in, so the first NOP is launched while the last
  // loaded word is on the bus and PAD writes run back to back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 32'd0;
      widx    <= '0;
      len_q   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept_start && !len_bad) begin
        widx  <= '0;
        len_q <= len;
      end else if (word_vld) begin
        wr_en   <= 1'b1;
        wr_addr <= widx[AW-1:0];
        wr_data <= word_dat;
        widx    <= widx + 1'b1;
      end else if (last_wr && (len_q != DEPTH_L)) begin
        wr_en   <= 1'b1;
        wr_addr <= len_q[AW-1:0];
        wr_data <= nop_ext[31:0];
      end else if ((state == PAD) && !pad_last) begin
        wr_en   <= 1'b1;
        wr_addr <= wr_addr + 1'b1;
        wr_data <= nop_ext[31:0];
      end
    end
  end

endmodule
